// File: rtl/alu_ctrl_seq_if.sv
// Handshake bundle between instruction decode and the ALU-control sequencer.
// master = decode/ALU side, slave = alu_ctrl_seq.
interface alu_ctrl_seq_if #(
  parameter int unsigned ALUOP_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               out_valid;
  logic               out_ready;
  logic [ALUOP_W-1:0] alu_op;
  logic               illegal;
  logic               is_md;
  logic               md_busy;

  modport master (
    output in_valid, op, funct, out_ready,
    input  in_ready, out_valid, alu_op, illegal, is_md, md_busy
  );

  modport slave (
    input  in_valid, op, funct, out_ready,
    output in_ready, out_valid, alu_op, illegal, is_md, md_busy
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered MIPS ALU-control decoder with valid/ready handshakes and optional
// multi-cycle mult/div sequencing, enabled by defining ALUCTRL_MDU_EN.
module alu_ctrl_seq #(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned MD_LAT  = 4
) (
  input logic           clk,
  input logic           rst,
  alu_ctrl_seq_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FULL = 2'd2;
`ifdef ALUCTRL_MDU_EN
  localparam logic [1:0] BUSY = 2'd1;
`endif

  logic [1:0] state;
  logic [3:0] op_q;
  logic       ill_q;
  logic [3:0] dec_op;
  logic       dec_ill;
  logic       dec_md;
  logic       acc;

  always_comb begin
    dec_op  = 4'd0;
    dec_ill = 1'b0;
    dec_md  = 1'b0;
    case (bus.op)
      6'h00: begin
        case (bus.funct)
          6'h00: dec_op = 4'd0;
          6'h03: dec_op = 4'd1;
          6'h02: dec_op = 4'd2;
`ifdef ALUCTRL_MDU_EN
          6'h18: begin dec_op = 4'd3; dec_md = 1'b1; end
          6'h1A: begin dec_op = 4'd4; dec_md = 1'b1; end
`endif
          6'h20, 6'h21, 6'h08, 6'h0C: dec_op = 4'd5;
          6'h22, 6'h23: dec_op = 4'd6;
          6'h24: dec_op = 4'd7;
          6'h25: dec_op = 4'd8;
          6'h26: dec_op = 4'd9;
          6'h27: dec_op = 4'd10;
          6'h2A: dec_op = 4'd11;
          6'h2B: dec_op = 4'd12;
          default: dec_ill = 1'b1;
        endcase
      end
      6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h10, 6'h23, 6'h2B: dec_op = 4'd5;
      6'h0C: dec_op = 4'd7;
      6'h0D: dec_op = 4'd8;
      6'h0E: dec_op = 4'd9;
      6'h0A: dec_op = 4'd11;
      6'h0B: dec_op = 4'd12;
      default: dec_ill = 1'b1;
    endcase
  end

  // in_ready is forced low during reset so nothing is accepted on a reset edge.
  assign bus.in_ready  = !rst && ((state == IDLE) || ((state == FULL) && bus.out_ready));
  assign acc           = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == FULL);
  assign bus.illegal   = ill_q;

  always_comb begin
    bus.alu_op      = '0;
    bus.alu_op[3:0] = op_q;
  end

`ifdef ALUCTRL_MDU_EN
  logic [7:0] cnt;

  assign bus.md_busy = (state == BUSY);
  assign bus.is_md   = (op_q == 4'd3) || (op_q == 4'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      case (state)
        IDLE, FULL: begin
          if (acc) begin
            op_q  <= dec_op;
            ill_q <= dec_ill;
            state <= dec_md ? BUSY : FULL;
            if (dec_md) cnt <= 8'(MD_LAT - 1);
          end else if ((state == FULL) && bus.out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else             state <= FULL;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign bus.md_busy = 1'b0;
  assign bus.is_md   = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      if (acc) begin
        op_q  <= dec_op;
        ill_q <= dec_ill;
        state <= FULL;
      end else if ((state == FULL) && bus.out_ready) begin
        state <= IDLE;
      end
    end
  end

  logic unused_dec_md;
  assign unused_dec_md = dec_md;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: reset, decode sweep, streaming,
// backpressure and (when ALUCTRL_MDU_EN is defined) mult/div sequencing.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.ALUOP_W(4)) bus ();
  alu_ctrl_seq_if #(.ALUOP_W(4)) b1 ();

  alu_ctrl_seq #(.ALUOP_W(4), .MD_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_ctrl_seq #(.ALUOP_W(4), .MD_LAT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [5:0] op, input logic [5:0] funct,
                     input logic [3:0] code, input logic ill);
    vec_t v;
    v.op = op; v.funct = funct; v.code = code; v.ill = ill;
    vt.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b1; bus.op = 6'h0D; bus.funct = 6'h00; bus.out_ready = 1'b1;
    b1.in_valid  = 1'b0; b1.op  = 6'h00; b1.funct  = 6'h00; b1.out_ready  = 1'b1;

    // Reset held two edges with in_valid asserted.
    tick(); tick();
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_alu_op",    32'(bus.alu_op),    32'd0);
    check("rst_illegal",   32'(bus.illegal),   32'd0);
    check("rst_is_md",     32'(bus.is_md),     32'd0);
    check("rst_md_busy",   32'(bus.md_busy),   32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("b1_post_rst_in_ready", 32'(b1.in_ready), 32'd1);

    // First single-cycle decode.
    bus.in_valid = 1'b1; bus.op = 6'h0D;
    tick();
    bus.in_valid = 1'b0;
    check("ori_out_valid", 32'(bus.out_valid), 32'd1);
    check("ori_alu_op",    32'(bus.alu_op),    32'd8);
    check("ori_illegal",   32'(bus.illegal),   32'd0);
    tick();
    check("ori_drain", 32'(bus.out_valid), 32'd0);

    // Full decode sweep, streamed back-to-back.
    add(6'h02, 6'h00, 4'd5, 1'b0);  add(6'h03, 6'h00, 4'd5, 1'b0);
    add(6'h04, 6'h00, 4'd5, 1'b0);  add(6'h05, 6'h00, 4'd5, 1'b0);
    add(6'h08, 6'h00, 4'd5, 1'b0);  add(6'h09, 6'h00, 4'd5, 1'b0);
    add(6'h10, 6'h00, 4'd5, 1'b0);  add(6'h23, 6'h00, 4'd5, 1'b0);
    add(6'h2B, 6'h00, 4'd5, 1'b0);  add(6'h0C, 6'h00, 4'd7, 1'b0);
    add(6'h0D, 6'h00, 4'd8, 1'b0);  add(6'h0E, 6'h00, 4'd9, 1'b0);
    add(6'h0A, 6'h00, 4'd11, 1'b0); add(6'h0B, 6'h00, 4'd12, 1'b0);
    add(6'h00, 6'h00, 4'd0, 1'b0);  add(6'h00, 6'h03, 4'd1, 1'b0);
    add(6'h00, 6'h02, 4'd2, 1'b0);  add(6'h00, 6'h20, 4'd5, 1'b0);
    add(6'h00, 6'h21, 4'd5, 1'b0);  add(6'h00, 6'h08, 4'd5, 1'b0);
    add(6'h00, 6'h0C, 4'd5, 1'b0);  add(6'h00, 6'h22, 4'd6, 1'b0);
    add(6'h00, 6'h23, 4'd6, 1'b0);  add(6'h00, 6'h24, 4'd7, 1'b0);
    add(6'h00, 6'h25, 4'd8, 1'b0);  add(6'h00, 6'h26, 4'd9, 1'b0);
    add(6'h00, 6'h27, 4'd10, 1'b0); add(6'h00, 6'h2A, 4'd11, 1'b0);
    add(6'h00, 6'h2B, 4'd12, 1'b0);
    add(6'h3F, 6'h00, 4'd0, 1'b1);  add(6'h01, 6'h00, 4'd0, 1'b1);
    add(6'h00, 6'h01, 4'd0, 1'b1);  add(6'h00, 6'h3F, 4'd0, 1'b1);
    add(6'h0C, 6'h00, 4'd7, 1'b0);  add(6'h0A, 6'h00, 4'd11, 1'b0);
    add(6'h00, 6'h27, 4'd10, 1'b0);
    foreach (vt[i]) begin
      bus.in_valid = 1'b1; bus.op = vt[i].op; bus.funct = vt[i].funct;
      #1;
      check($sformatf("sweep%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      check($sformatf("sweep%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("sweep%0d_alu_op", i),    32'(bus.alu_op),    32'(vt[i].code));
      check($sformatf("sweep%0d_illegal", i),   32'(bus.illegal),   32'(vt[i].ill));
    end
    bus.in_valid = 1'b0;
    tick();
    check("sweep_drain", 32'(bus.out_valid), 32'd0);

    // Backpressure: xori held for 3 cycles while ori waits.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = 6'h0E;
    tick();
    bus.op = 6'h0D;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp%0d_alu_op", k),    32'(bus.alu_op),    32'd9);
      check($sformatf("bp%0d_in_ready", k),  32'(bus.in_ready),  32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_next_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_next_alu_op",    32'(bus.alu_op),    32'd8);
    tick();
    check("bp_drain", 32'(bus.out_valid), 32'd0);

`ifdef ALUCTRL_MDU_EN
    // Mult with MD_LAT=4; a pending ori must be ignored while busy.
    bus.in_valid = 1'b1; bus.op = 6'h00; bus.funct = 6'h18;
    tick();
    bus.op = 6'h0D; bus.funct = 6'h00;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("mul_c%0d_md_busy", k),   32'(bus.md_busy),   32'd1);
      check($sformatf("mul_c%0d_out_valid", k), 32'(bus.out_valid), 32'd0);
      check($sformatf("mul_c%0d_in_ready", k),  32'(bus.in_ready),  32'd0);
      check($sformatf("mul_c%0d_alu_op", k),    32'(bus.alu_op),    32'd3);
      tick();
    end
    bus.in_valid = 1'b0;
    check("mul_out_valid", 32'(bus.out_valid), 32'd1);
    check("mul_alu_op",    32'(bus.alu_op),    32'd3);
    check("mul_is_md",     32'(bus.is_md),     32'd1);
    check("mul_md_busy",   32'(bus.md_busy),   32'd0);
    tick();
    check("mul_drain", 32'(bus.out_valid), 32'd0);

    // Mult with MD_LAT=1.
    b1.in_valid = 1'b1; b1.op = 6'h00; b1.funct = 6'h18;
    tick();
    b1.in_valid = 1'b0;
    check("mul1_md_busy",   32'(b1.md_busy),   32'd1);
    check("mul1_out_valid", 32'(b1.out_valid), 32'd0);
    tick();
    check("mul1_done_valid", 32'(b1.out_valid), 32'd1);
    check("mul1_alu_op",     32'(b1.alu_op),    32'd3);
    check("mul1_is_md",      32'(b1.is_md),     32'd1);
    tick();

    // Reset asserted in cycle N+2 of a div.
    bus.in_valid = 1'b1; bus.op = 6'h00; bus.funct = 6'h1A;
    tick();
    bus.in_valid = 1'b0;
    check("div_c1_md_busy", 32'(bus.md_busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("div_rst_md_busy",   32'(bus.md_busy),   32'd0);
    check("div_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("div_rst_alu_op",    32'(bus.alu_op),    32'd0);
    check("div_rst_in_ready",  32'(bus.in_ready),  32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("div_dropped%0d", k), 32'(bus.out_valid), 32'd0);
    end
`else
    // Without the MDU, mult/div are single-cycle illegal ops.
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1; bus.op = 6'h00; bus.funct = (k == 0) ? 6'h18 : 6'h1A;
      tick();
      bus.in_valid = 1'b0;
      check($sformatf("nomd%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("nomd%0d_alu_op", k),    32'(bus.alu_op),    32'd0);
      check($sformatf("nomd%0d_illegal", k),   32'(bus.illegal),   32'd1);
      check($sformatf("nomd%0d_md_busy", k),   32'(bus.md_busy),   32'd0);
      check($sformatf("nomd%0d_is_md", k),     32'(bus.is_md),     32'd0);
      tick();
    end
    check("nomd_b1_md_busy", 32'(b1.md_busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, handshaked ALU-control decoder for the MIPS core. It is the successor to the combinational opcode-to-ALUop decoder and adds R-type `funct` decoding, two extra I-type ops, and an illegal-instruction flag. It also sequences multi-cycle multiply/divide, holding the decode stage for a configurable latency. It sits between instruction decode and the ALU/MDU, with valid/ready handshakes on both sides.

## Interface
- `ALUOP_W`, 4: width of `alu_op`; must be ≥4; bits above [3] are driven 0.
- `MD_LAT`, 4: busy cycles for mult/div; legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `op`/`funct` are valid.
- `in_ready` out 1: block accepts this cycle.
- `op` in 6: instruction[31:26].
- `funct` in 6: instruction[5:0]; used only when `op`==0x00.
- `out_valid` out 1: `alu_op`, `illegal` and `is_md` are valid.
- `out_ready` in 1: downstream consumes this cycle.
- `alu_op` out ALUOP_W: registered ALU operation code.
- `illegal` out 1: decoded instruction is unsupported.
- `is_md` out 1: the held result is a mult/div.
- `md_busy` out 1: MDU sequencing in progress (BUSY state).

## Operation
- ALU codes: 0 sll, 1 sra, 2 srl, 3 mul, 4 div, 5 add, 6 sub, 7 and, 8 or, 9 xor, 10 nor, 11 slt, 12 sltu.
- I-type decode:
  - op 0x02, 0x03, 0x04, 0x05, 0x08, 0x09, 0x10, 0x23, 0x2B → 5.
  - 0x0C → 7; 0x0D → 8; 0x0E → 9; 0x0A → 11; 0x0B → 12.
- R-type decode (op 0x00), by `funct`:
  - 0x00 → 0; 0x03 → 1; 0x02 → 2; 0x18 → 3; 0x1A → 4.
  - 0x20, 0x21, 0x08, 0x0C → 5; 0x22, 0x23 → 6.
  - 0x24 → 7; 0x25 → 8; 0x26 → 9; 0x27 → 10; 0x2A → 11; 0x2B → 12.
- Any other op/funct → `alu_op`=0, `illegal`=1. Illegal instructions still complete as single-cycle ops.
- FSM states:
  - IDLE: output register empty.
  - BUSY: counting MDU latency.
  - FULL: result held.
- Accept condition: `acc` = `in_valid` & `in_ready`.
- `in_ready` = !`rst` & (state==IDLE | (state==FULL & `out_ready`)).
- IDLE: on `acc`, register the decode result.
  - Non-mult/div → FULL.
  - Mult/div → BUSY, with `cnt` loaded to MD_LAT-1.
- BUSY: `cnt`≠0 decrements; `cnt`==0 → FULL. `in_valid` is ignored while in BUSY.
- FULL, `out_ready`=1:
  - With `acc`: load the new instruction (FULL or BUSY per op). This gives back-to-back throughput of 1/cycle.
  - Without `acc` → IDLE.
- FULL, `out_ready`=0: hold all outputs stable.
- `out_valid` = (state==FULL); `md_busy` = (state==BUSY).
- `is_md` = 1 iff the registered `alu_op` is 3 or 4.

## Timing
- Reset values: state IDLE, `cnt`=0, `alu_op`=0, `illegal`=0, `is_md`=0, `out_valid`=0, `md_busy`=0, `in_ready`=0 (combinationally, while `rst` is high).
- `rst` asserted in any state (including mid-BUSY) returns the block to reset values at the next edge. Any pending result is dropped; no partial output is produced.
- Single-cycle op accepted at edge N: `out_valid`=1 in cycle N+1.
- Mult/div accepted at edge N:
  - `md_busy`=1 in cycles N+1..N+MD_LAT.
  - `out_valid`=1 in cycle N+MD_LAT+1.
  - `in_ready`=0 throughout BUSY.
- `alu_op` is stable from the accepting edge onward (in BUSY and FULL) until the next accept.
- Simultaneous FULL & `out_ready` & `in_valid`: the old result is consumed and the new one loaded on the same edge. No bubble and no loss.
- `out_ready` is ignored outside FULL.

## Configuration
- `ALUCTRL_MDU_EN` defined:
  - mult (0x18) and div (0x1A) decode to 3 and 4 and use the BUSY state.
- `ALUCTRL_MDU_EN` undefined:
  - 0x18 and 0x1A decode as illegal (`alu_op`=0, `illegal`=1).
  - No BUSY state and no counter; `md_busy` and `is_md` are tied to 0; `MD_LAT` is unused.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid`=1 → `in_ready`=0, all outputs 0. First cycle after reset → `in_ready`=1.
- Single-cycle decode: op=0x0D, `out_ready`=1 → next cycle `out_valid`=1, `alu_op`=8, `illegal`=0.
  - Sweep every listed op/funct against its code.
  - op=0x3F → `illegal`=1, `alu_op`=0.
- Back-to-back: stream op 0x0C, 0x0A, 0x00/funct 0x27 with `out_ready`=1 → outputs 7, 11, 10 on consecutive cycles, `in_ready` constantly 1.
- Backpressure: `out_ready`=0 for 3 cycles after op=0x0E → `alu_op`=9 held, `in_ready`=0. Release → the next instruction loads on the same edge.
- Mult (MDU_EN, MD_LAT=4): funct 0x18 accepted at N → `md_busy`=1 for cycles N+1..N+4, `in_valid` ignored, `out_valid`=1 in N+5 with `alu_op`=3, `is_md`=1.
  - Repeat with MD_LAT=1 → `out_valid`=1 in N+2.
- Reset mid-BUSY: assert `rst` at cycle N+2 of a div → at the next edge `md_busy`=0, `out_valid`=0, state IDLE, and no result is ever presented.
